// File: rtl/mac_pipe_pkg.sv
// mac_pkg: shared widths, op encodings and saturation constants for mac_pipe.
package mac_pkg;

  // Op code is {accum, sub}, captured with the operands at the input register.
  localparam logic [1:0] OP_LOAD     = 2'b00;
  localparam logic [1:0] OP_LOAD_NEG = 2'b01;
  localparam logic [1:0] OP_ADD      = 2'b10;
  localparam logic [1:0] OP_SUB      = 2'b11;

  function automatic int unsigned out_width(input int unsigned a_width,
                                            input int unsigned b_width,
                                            input int unsigned acc_guard);
    return a_width + b_width + acc_guard;
  endfunction

  // Largest representable accumulator value, as a bit pattern in the low ow bits.
  function automatic logic [63:0] sat_max(input int unsigned ow, input bit is_signed);
    return is_signed ? ((64'd1 << (ow - 1)) - 64'd1) : ((64'd1 << ow) - 64'd1);
  endfunction

  // Smallest representable accumulator value, as a bit pattern in the low ow bits.
  function automatic logic [63:0] sat_min(input int unsigned ow, input bit is_signed);
    return is_signed ? (64'd1 << (ow - 1)) : 64'd0;
  endfunction

endpackage

// File: rtl/mac_pipe_if.sv
// mac_pipe_if: operand/control bundle into mac_pipe and the result bundle back out.
interface mac_pipe_if #(
  parameter int unsigned A_WIDTH = 16,
  parameter int unsigned B_WIDTH = 16,
  parameter int unsigned OW      = 32
) ();
  logic               ce;
  logic               in_valid;
  logic [A_WIDTH-1:0] a;
  logic [B_WIDTH-1:0] b;
  logic               accum;
  logic               sub;
  logic               out_valid;
  logic [OW-1:0]      o;
  logic               ovf;

  modport master (output ce, in_valid, a, b, accum, sub, input out_valid, o, ovf);
  modport slave  (input ce, in_valid, a, b, accum, sub, output out_valid, o, ovf);
endinterface

// File: rtl/mac_mult_pipe.sv
// mac_mult_pipe: input register followed by MULT_STAGES product registers, with the
// valid bit and op code carried alongside. Every register holds while i_ce is low.
module mac_mult_pipe #(
  parameter int unsigned A_WIDTH     = 16,
  parameter int unsigned B_WIDTH     = 16,
  parameter bit          SIGNED      = 1'b0,
  parameter int unsigned MULT_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_ce,
  input  logic                       i_valid,
  input  logic [A_WIDTH-1:0]         i_a,
  input  logic [B_WIDTH-1:0]         i_b,
  input  logic [1:0]                 i_op,
  output logic                       o_valid,
  output logic [1:0]                 o_op,
  output logic [A_WIDTH+B_WIDTH-1:0] o_prod
);
  localparam int unsigned PW = A_WIDTH + B_WIDTH;

  logic               r_in_valid;
  logic [A_WIDTH-1:0] r_a;
  logic [B_WIDTH-1:0] r_b;
  logic [1:0]         r_in_op;
  logic               r_pv  [MULT_STAGES];
  logic [1:0]         r_pop [MULT_STAGES];
  logic [PW-1:0]      r_p   [MULT_STAGES];

  logic [PW-1:0] w_a_ext;
  logic [PW-1:0] w_b_ext;
  logic [PW-1:0] w_prod;

  // Low PW bits of the product of PW-extended operands equal the exact signed or
  // unsigned product, which always fits in PW bits.
  assign w_a_ext = SIGNED ? PW'($signed(r_a)) : PW'(r_a);
  assign w_b_ext = SIGNED ? PW'($signed(r_b)) : PW'(r_b);
  assign w_prod  = w_a_ext * w_b_ext;

  // Input capture and product shift chain, all gated by the pipeline enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_valid <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_in_op    <= '0;
      for (int i = 0; i < MULT_STAGES; i++) begin
        r_pv[i]  <= 1'b0;
        r_pop[i] <= '0;
        r_p[i]   <= '0;
      end
    end else if (i_ce) begin
      r_in_valid <= i_valid;
      r_a        <= i_a;
      r_b        <= i_b;
      r_in_op    <= i_op;
      r_pv[0]    <= r_in_valid;
      r_pop[0]   <= r_in_op;
      r_p[0]     <= w_prod;
      for (int i = 1; i < MULT_STAGES; i++) begin
        r_pv[i]  <= r_pv[i-1];
        r_pop[i] <= r_pop[i-1];
        r_p[i]   <= r_p[i-1];
      end
    end
  end

  assign o_valid = r_pv[MULT_STAGES-1];
  assign o_op    = r_pop[MULT_STAGES-1];
  assign o_prod  = r_p[MULT_STAGES-1];

endmodule

// File: rtl/mac_pipe.sv
// mac_pipe: pipelined multiply-accumulate with per-entry load/add/sub control and a
// sticky overflow flag. Define MAC_PIPE_SATURATE_EN to clamp on accumulate overflow
// instead of wrapping modulo 2^OW.
module mac_pipe
  import mac_pkg::*;
#(
  parameter int unsigned A_WIDTH     = 16,
  parameter int unsigned B_WIDTH     = 16,
  parameter bit          SIGNED      = 1'b0,
  parameter int unsigned MULT_STAGES = 2,
  parameter int unsigned ACC_GUARD   = 0
) (
  input  logic      clk,
  input  logic      reset,
  mac_pipe_if.slave bus
);
  localparam int unsigned PW = A_WIDTH + B_WIDTH;
  localparam int unsigned OW = out_width(A_WIDTH, B_WIDTH, ACC_GUARD);

  logic          w_valid;
  logic [1:0]    w_op;
  logic [PW-1:0] w_prod;
  logic [OW-1:0] w_p_ext;
  logic [OW-1:0] w_res;
  logic [OW:0]   w_sum;
  logic          w_ovf_now;

  logic          r_out_valid;
  logic [OW-1:0] r_o;
  logic          r_ovf;

  mac_mult_pipe #(
    .A_WIDTH    (A_WIDTH),
    .B_WIDTH    (B_WIDTH),
    .SIGNED     (SIGNED),
    .MULT_STAGES(MULT_STAGES)
  ) u_mult (
    .clk    (clk),
    .reset  (reset),
    .i_ce   (bus.ce),
    .i_valid(bus.in_valid),
    .i_a    (bus.a),
    .i_b    (bus.b),
    .i_op   ({bus.accum, bus.sub}),
    .o_valid(w_valid),
    .o_op   (w_op),
    .o_prod (w_prod)
  );

  assign w_p_ext = SIGNED ? OW'($signed(w_prod)) : OW'(w_prod);

`ifdef MAC_PIPE_SATURATE_EN
  localparam logic [63:0]   SAT_MAX64 = sat_max(OW, SIGNED);
  localparam logic [63:0]   SAT_MIN64 = sat_min(OW, SIGNED);
  localparam logic [OW-1:0] SAT_MAX   = SAT_MAX64[OW-1:0];
  localparam logic [OW-1:0] SAT_MIN   = SAT_MIN64[OW-1:0];

  logic [OW-1:0] w_sat;
  // Signed overflow always runs away from the accumulator's own sign.
  assign w_sat = SIGNED ? (r_o[OW-1] ? SAT_MIN : SAT_MAX)
                        : ((w_op == OP_ADD) ? SAT_MAX : SAT_MIN);
`endif

  // Next accumulator value and this entry's overflow, decoded from the op code.
  always_comb begin
    w_sum     = '0;
    w_res     = w_p_ext;
    w_ovf_now = 1'b0;
    unique case (w_op)
      OP_LOAD:     w_res = w_p_ext;
      OP_LOAD_NEG: w_res = -w_p_ext;
      OP_ADD: begin
        w_sum     = {1'b0, r_o} + {1'b0, w_p_ext};
        w_res     = w_sum[OW-1:0];
        w_ovf_now = SIGNED ? ((r_o[OW-1] == w_p_ext[OW-1]) && (w_sum[OW-1] != r_o[OW-1]))
                           : w_sum[OW];
      end
      OP_SUB: begin
        w_sum     = {1'b0, r_o} - {1'b0, w_p_ext};
        w_res     = w_sum[OW-1:0];
        // Product never reaches the most negative OW value, so -p is always exact.
        w_ovf_now = SIGNED ? ((r_o[OW-1] != w_p_ext[OW-1]) && (w_sum[OW-1] != r_o[OW-1]))
                           : w_sum[OW];
      end
      default: ;
    endcase
`ifdef MAC_PIPE_SATURATE_EN
    if (w_ovf_now) begin
      w_res = w_sat;
    end
`endif
  end

  // Accumulator stage: only valid entries touch o/ovf; loads clear the sticky flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_o         <= '0;
      r_ovf       <= 1'b0;
    end else if (bus.ce) begin
      r_out_valid <= w_valid;
      if (w_valid) begin
        r_o   <= w_res;
        r_ovf <= w_op[1] ? (r_ovf | w_ovf_now) : 1'b0;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.o         = r_o;
  assign bus.ovf       = r_ovf;

endmodule
